runway_arbiter: RTL and testbench
=================================

RUNWAY_ARBITER -- requirements
Module: runway_arbiter

Interface
REQ-001 Parameter OCC_CYCLES, default 8, runway occupancy time per grant in clk cycles (range 1..15).
REQ-002 Parameter HOLD_CYCLES, default 12, weather-hold countdown length in clk cycles (range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 land_req  input  1  landing request; held high until land_grant is seen.
REQ-006 emergency  input  1  the pending landing is an emergency; qualified by land_req.
REQ-007 fuel  input  2  landing aircraft fuel: 00 critical, 01/10 normal, 11 excess.
REQ-008 takeoff_signal  input  1  takeoff request; held high until takeoff_grant is seen.
REQ-009 gate_number  input  3  gate of the departing aircraft.
REQ-010 weather  input  1  1 = good, 0 = bad.
REQ-011 land_grant  output  1  one-cycle pulse granting the landing.
REQ-012 takeoff_grant  output  1  one-cycle pulse granting the takeoff.
REQ-013 allocated_runway  output  2  runway of the current grant; holds its last value between grants.
REQ-014 runway_busy  output  4  per-runway occupancy flags.
REQ-015 timer_active  output  1  weather hold in progress.
REQ-016 timer_value  output  4  remaining weather-hold cycles.

Function
REQ-017 Landing priority: a landing is priority class when emergency=1 or fuel=00, and normal class otherwise.
REQ-018 Landing runway choice:
- Priority class: runway 0 if free, else the lowest-numbered free runway 1..3.
- Normal class: runway 0 or 1, lowest free first.
REQ-019 Takeoff runway choice: gate_number 0..3 uses runway 2 and 4..7 uses runway 3, with no fallback.
REQ-020 The FSM has states IDLE, GRANT and WX_HOLD.
REQ-021 IDLE transitions:
- Go to GRANT when a request is eligible and its runway is free.
- Go to WX_HOLD when weather=0 and no priority-class landing is pending.
REQ-022 GRANT lasts exactly one cycle.
- Asserts exactly one grant pulse and drives allocated_runway.
- Sets the chosen runway_busy bit and loads that runway's counter with OCC_CYCLES.
- Returns to IDLE.
REQ-023 Latency: a request eligible in cycle N produces its grant pulse in cycle N+1.
- No new grant may occur in cycle N+2; the requester has one cycle to drop its request.
REQ-024 Arbitration order:
- Priority-class landing beats takeoff.
- Takeoff beats a landing with fuel=11.
- Otherwise takeoff and normal landing alternate, starting with landing after reset.
REQ-025 Occupancy: each busy runway counter decrements every cycle and clears its runway_busy bit the cycle it reaches 0.
- A runway is free when its runway_busy bit is 0.
REQ-026 Entering WX_HOLD loads timer_value=HOLD_CYCLES and sets timer_active=1.
- timer_value decrements by 1 per cycle.
REQ-027 Exiting WX_HOLD at timer_value=0:
- weather=1: return to IDLE and clear timer_active.
- weather=0: reload HOLD_CYCLES.
REQ-028 In WX_HOLD a priority-class landing is still granted (WX_HOLD to GRANT to WX_HOLD) and the countdown keeps running.
- Normal landings and takeoffs are held off.
REQ-029 Grants never go to a busy runway; if no eligible runway is free the request waits with no grant.
REQ-030 land_grant and takeoff_grant are never high in the same cycle.

Reset
REQ-031 Asserting rst returns the FSM to IDLE immediately, including mid-grant or mid-hold.
REQ-032 On reset every output is 0, all occupancy counters are 0, and the alternation pointer selects landing.
REQ-033 A request pending at reset release is evaluated in the first cycle after release.

Configuration
REQ-034 The macro RUNWAY_STATS_EN controls a statistics counter.
- Defined: adds output port grant_count (8 bits), incremented on every grant pulse, saturating at 255, cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-035 Scenario: emergency=1, land_req=1, weather=1, all runways free -> land_grant one cycle later, allocated_runway=00, runway_busy=0001 for 8 cycles.
REQ-036 Scenario: land_req (fuel=01) and takeoff_signal (gate_number=100) raised together -> land_grant on runway 0 first; takeoff_grant on runway 3 at the next free slot.
REQ-037 Scenario: weather=0 with a normal land_req pending -> timer_active=1, timer_value counts 12 down to 0; weather=1 at expiry -> land_grant follows.
REQ-038 Scenario: weather=0 during hold, then land_req with fuel=00 -> granted on runway 0 while timer_value keeps counting.
REQ-039 Scenario: runways 2 and 3 busy, takeoff_signal with gate_number=001 -> no grant until runway 2 frees, then takeoff_grant with allocated_runway=10.
REQ-040 Scenario: rst asserted mid-hold -> timer_active=0, timer_value=0, runway_busy=0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/runway_arbiter.sv
// Runway arbiter: grants landings and takeoffs onto four runways, tracks occupancy, runs a weather hold.
// Optional feature: define RUNWAY_STATS_EN to add a saturating grant_count output.
module runway_arbiter #(
   parameter int unsigned OCC_CYCLES  = 8,
   parameter int unsigned HOLD_CYCLES = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       land_req,
   input  logic       emergency,
   input  logic [1:0] fuel,
   input  logic       takeoff_signal,
   input  logic [2:0] gate_number,
   input  logic       weather,
   output logic       land_grant,
   output logic       takeoff_grant,
   output logic [1:0] allocated_runway,
   output logic [3:0] runway_busy,
   output logic       timer_active,
`ifdef RUNWAY_STATS_EN
   output logic [7:0] grant_count,
`endif
   output logic [3:0] timer_value
);

   localparam int unsigned RWY_N = 4;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, GRANT, WX_HOLD} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   occ_cnt   [RWY_N];
   logic [CNT_W-1:0]   occ_cnt_n [RWY_N];
   logic [RWY_N-1:0]   busy_n;
   logic               land_grant_n, takeoff_grant_n;
   logic [1:0]         runway_n;
   logic               tmr_act_n;
   logic [CNT_W-1:0]   tmr_val_n;
   logic               turn_to, turn_to_n;

   logic               prio_land, excess_land, land_free, to_free;
   logic [1:0]         land_rwy, to_rwy;
   logic               pick_land, pick_to, allow_all, allow_prio, do_land, do_to;

   // Request classification, runway choice and arbitration for this cycle.
   always_comb begin
      prio_land   = land_req && (emergency || fuel == 2'b00);
      excess_land = land_req && !prio_land && fuel == 2'b11;
      land_free   = 1'b0;
      land_rwy    = 2'd0;
      if (land_req) begin
         if (!runway_busy[0]) begin
            land_free = 1'b1;
            land_rwy  = 2'd0;
         end else if (!runway_busy[1]) begin
            land_free = 1'b1;
            land_rwy  = 2'd1;
         end else if (prio_land && !runway_busy[2]) begin
            land_free = 1'b1;
            land_rwy  = 2'd2;
         end else if (prio_land && !runway_busy[3]) begin
            land_free = 1'b1;
            land_rwy  = 2'd3;
         end
      end
      to_rwy  = (gate_number >= 3'd4) ? 2'd3 : 2'd2;
      to_free = takeoff_signal && !runway_busy[to_rwy];

      pick_land = 1'b0;
      pick_to   = 1'b0;
      if (prio_land && land_free) begin
         pick_land = 1'b1;
      end else if (excess_land) begin
         if (to_free)        pick_to   = 1'b1;
         else if (land_free) pick_land = 1'b1;
      end else if (land_free && to_free) begin
         pick_to   = turn_to;
         pick_land = !turn_to;
      end else if (land_free) begin
         pick_land = 1'b1;
      end else if (to_free) begin
         pick_to = 1'b1;
      end

      // Bad weather or an active hold admits only priority landings.
      allow_all  = (state == IDLE) && weather;
      allow_prio = (state == IDLE) || (state == WX_HOLD);
      do_land    = pick_land && (allow_all || (allow_prio && prio_land));
      do_to      = pick_to && allow_all;
   end

   // Next-state, grant, occupancy and hold-timer logic.
   always_comb begin
      state_n         = state;
      land_grant_n    = 1'b0;
      takeoff_grant_n = 1'b0;
      runway_n        = allocated_runway;
      turn_to_n       = turn_to;
      tmr_act_n       = timer_active;
      tmr_val_n       = timer_value;
      for (int i = 0; i < RWY_N; i++) begin
         occ_cnt_n[i] = (occ_cnt[i] != '0) ? occ_cnt[i] - 4'd1 : '0;
      end

      if (timer_active) begin
         if (timer_value != '0) tmr_val_n = timer_value - 4'd1;
         else if (weather)      tmr_act_n = 1'b0;
         else                   tmr_val_n = CNT_W'(HOLD_CYCLES);
      end

      if (do_land || do_to) begin
         land_grant_n        = do_land;
         takeoff_grant_n     = do_to;
         runway_n            = do_land ? land_rwy : to_rwy;
         occ_cnt_n[runway_n] = CNT_W'(OCC_CYCLES);
         if (do_to)           turn_to_n = 1'b0;
         else if (!prio_land) turn_to_n = 1'b1;
      end

      unique case (state)
         IDLE: begin
            if (do_land || do_to) begin
               state_n = GRANT;
            end else if (!weather && !prio_land) begin
               state_n   = WX_HOLD;
               tmr_act_n = 1'b1;
               tmr_val_n = CNT_W'(HOLD_CYCLES);
            end
         end
         GRANT:   state_n = tmr_act_n ? WX_HOLD : IDLE;
         WX_HOLD: begin
            if (do_land)         state_n = GRANT;
            else if (!tmr_act_n) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      for (int i = 0; i < RWY_N; i++) begin
         busy_n[i] = (occ_cnt_n[i] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         land_grant       <= 1'b0;
         takeoff_grant    <= 1'b0;
         allocated_runway <= 2'd0;
         runway_busy      <= '0;
         timer_active     <= 1'b0;
         timer_value      <= '0;
         turn_to          <= 1'b0;
         for (int i = 0; i < RWY_N; i++) occ_cnt[i] <= '0;
      end else begin
         state            <= state_n;
         land_grant       <= land_grant_n;
         takeoff_grant    <= takeoff_grant_n;
         allocated_runway <= runway_n;
         runway_busy      <= busy_n;
         timer_active     <= tmr_act_n;
         timer_value      <= tmr_val_n;
         turn_to          <= turn_to_n;
         for (int i = 0; i < RWY_N; i++) occ_cnt[i] <= occ_cnt_n[i];
      end
   end

`ifdef RUNWAY_STATS_EN
   // Saturating count of grant pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         grant_count <= '0;
      else if ((land_grant_n || takeoff_grant_n) && grant_count != 8'hFF)
         grant_count <= grant_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_runway_arbiter.sv
// Directed self-checking bench for runway_arbiter (default parameters OCC=8, HOLD=12).
module tb_runway_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       land_req, emergency, takeoff_signal, weather;
   logic [1:0] fuel;
   logic [2:0] gate_number;
   logic       land_grant, takeoff_grant, timer_active;
   logic [1:0] allocated_runway;
   logic [3:0] runway_busy, timer_value;
`ifdef RUNWAY_STATS_EN
   logic [7:0] grant_count;
`endif

   int checks = 0;
   int errors = 0;

   runway_arbiter dut (
      .clk(clk), .rst(rst), .land_req(land_req), .emergency(emergency), .fuel(fuel),
      .takeoff_signal(takeoff_signal), .gate_number(gate_number), .weather(weather),
      .land_grant(land_grant), .takeoff_grant(takeoff_grant),
      .allocated_runway(allocated_runway), .runway_busy(runway_busy),
      .timer_active(timer_active),
`ifdef RUNWAY_STATS_EN
      .grant_count(grant_count),
`endif
      .timer_value(timer_value)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      repeat (12) tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; land_req = 1'b0; emergency = 1'b0; fuel = 2'b01;
      takeoff_signal = 1'b0; gate_number = 3'd0; weather = 1'b1;
      repeat (2) tick();
      checks++; if (land_grant !== 1'b0) begin errors++; $display("FAIL rst_land_grant: got %b expected 0", land_grant); end
      checks++; if (takeoff_grant !== 1'b0) begin errors++; $display("FAIL rst_takeoff_grant: got %b expected 0", takeoff_grant); end
      checks++; if (allocated_runway !== 2'd0) begin errors++; $display("FAIL rst_runway: got %0d expected 0", allocated_runway); end
      checks++; if (runway_busy !== 4'b0000) begin errors++; $display("FAIL rst_busy: got %b expected 0000", runway_busy); end
      checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL rst_timer_active: got %b expected 0", timer_active); end
      checks++; if (timer_value !== 4'd0) begin errors++; $display("FAIL rst_timer_value: got %0d expected 0", timer_value); end
      rst = 1'b0;
      tick();
      checks++; if (land_grant !== 1'b0 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL idle_no_grant: got %b%b expected 00", land_grant, takeoff_grant); end
   endtask

   task automatic test_emergency;
      emergency = 1'b1; land_req = 1'b1; fuel = 2'b01;
      tick();
      checks++; if (land_grant !== 1'b1) begin errors++; $display("FAIL emerg_grant: got %b expected 1", land_grant); end
      checks++; if (takeoff_grant !== 1'b0) begin errors++; $display("FAIL emerg_no_takeoff: got %b expected 0", takeoff_grant); end
      checks++; if (allocated_runway !== 2'd0) begin errors++; $display("FAIL emerg_runway: got %0d expected 0", allocated_runway); end
      checks++; if (runway_busy !== 4'b0001) begin errors++; $display("FAIL emerg_busy: got %b expected 0001", runway_busy); end
      land_req = 1'b0; emergency = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         checks++; if (runway_busy !== 4'b0001) begin errors++; $display("FAIL emerg_busy_hold%0d: got %b expected 0001", k, runway_busy); end
         checks++; if (land_grant !== 1'b0) begin errors++; $display("FAIL emerg_single_pulse%0d: got %b expected 0", k, land_grant); end
      end
      tick();
      checks++; if (runway_busy !== 4'b0000) begin errors++; $display("FAIL emerg_busy_clear: got %b expected 0000", runway_busy); end
      drain();
   endtask

   task automatic test_simultaneous;
      land_req = 1'b1; fuel = 2'b01; takeoff_signal = 1'b1; gate_number = 3'b100;
      tick();
      checks++; if (land_grant !== 1'b1 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL sim_land_first: got %b%b expected 10", land_grant, takeoff_grant); end
      checks++; if (allocated_runway !== 2'd0) begin errors++; $display("FAIL sim_land_runway: got %0d expected 0", allocated_runway); end
      land_req = 1'b0;
      tick();
      checks++; if (land_grant !== 1'b0 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL sim_gap: got %b%b expected 00", land_grant, takeoff_grant); end
      tick();
      checks++; if (takeoff_grant !== 1'b1 || land_grant !== 1'b0) begin errors++; $display("FAIL sim_takeoff: got %b%b expected 01", land_grant, takeoff_grant); end
      checks++; if (allocated_runway !== 2'd3) begin errors++; $display("FAIL sim_takeoff_runway: got %0d expected 3", allocated_runway); end
      checks++; if (runway_busy !== 4'b1001) begin errors++; $display("FAIL sim_busy: got %b expected 1001", runway_busy); end
      takeoff_signal = 1'b0;
      drain();
   endtask

   task automatic test_excess_fuel;
      land_req = 1'b1; fuel = 2'b11; takeoff_signal = 1'b1; gate_number = 3'd1;
      tick();
      checks++; if (takeoff_grant !== 1'b1 || land_grant !== 1'b0) begin errors++; $display("FAIL excess_takeoff_first: got %b%b expected 01", land_grant, takeoff_grant); end
      checks++; if (allocated_runway !== 2'd2) begin errors++; $display("FAIL excess_takeoff_runway: got %0d expected 2", allocated_runway); end
      takeoff_signal = 1'b0;
      tick();
      checks++; if (land_grant !== 1'b0 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL excess_gap: got %b%b expected 00", land_grant, takeoff_grant); end
      tick();
      checks++; if (land_grant !== 1'b1) begin errors++; $display("FAIL excess_land: got %b expected 1", land_grant); end
      checks++; if (allocated_runway !== 2'd0) begin errors++; $display("FAIL excess_land_runway: got %0d expected 0", allocated_runway); end
      land_req = 1'b0;
      drain();
   endtask

   task automatic test_alternate;
      // The preceding landing leaves the turn with takeoff.
      land_req = 1'b1; fuel = 2'b10; takeoff_signal = 1'b1; gate_number = 3'd5;
      tick();
      checks++; if (takeoff_grant !== 1'b1 || land_grant !== 1'b0) begin errors++; $display("FAIL alt_takeoff_first: got %b%b expected 01", land_grant, takeoff_grant); end
      checks++; if (allocated_runway !== 2'd3) begin errors++; $display("FAIL alt_takeoff_runway: got %0d expected 3", allocated_runway); end
      takeoff_signal = 1'b0;
      tick();
      takeoff_signal = 1'b1; gate_number = 3'd0;
      tick();
      checks++; if (land_grant !== 1'b1 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL alt_land_second: got %b%b expected 10", land_grant, takeoff_grant); end
      checks++; if (allocated_runway !== 2'd0) begin errors++; $display("FAIL alt_land_runway: got %0d expected 0", allocated_runway); end
      land_req = 1'b0;
      tick();
      checks++; if (land_grant !== 1'b0 || takeoff_grant !== 1'b0) begin errors++; $display("FAIL alt_gap: got %b%b expected 00", land_grant, takeoff_grant); end
      tick();
      checks++; if (takeoff_grant !== 1'b1) begin errors++; $display("FAIL alt_takeoff_third: got %b expected 1", takeoff_grant); end
      checks++; if (allocated_runway !== 2'd2) begin errors++; $display("FAIL alt_third_runway: got %0d expected 2", allocated_runway); end
      checks++; if (runway_busy !== 4'b1101) begin errors++; $display("FAIL alt_busy: got %b expected 1101", runway_busy); end
      takeoff_signal = 1'b0;
      drain();
   endtask

   task automatic test_busy_wait;
      takeoff_signal = 1'b1; gate_number = 3'd0;
      tick();
      checks++; if (takeoff_grant !== 1'b1 || allocated_runway !== 2'd2) begin errors++; $display("FAIL bw_fill2: got %b/%0d expected 1/2", takeoff_grant, allocated_runway); end
      gate_number = 3'd7;
      tick();
      tick();
      checks++; if (takeoff_grant !== 1'b1 || allocated_runway !== 2'd3) begin errors++; $display("FAIL bw_fill3: got %b/%0d expected 1/3", takeoff_grant, allocated_runway); end
      checks++; if (runway_busy !== 4'b1100) begin errors++; $display("FAIL bw_busy_full: got %b expected 1100", runway_busy); end
      gate_number = 3'b001;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (takeoff_grant !== 1'b0) begin errors++; $display("FAIL bw_waiting%0d: got %b expected 0", k, takeoff_grant); end
      end
      checks++; if (runway_busy !== 4'b1000) begin errors++; $display("FAIL bw_rwy2_freed: got %b expected 1000", runway_busy); end
      tick();
      checks++; if (takeoff_grant !== 1'b1) begin errors++; $display("FAIL bw_grant: got %b expected 1", takeoff_grant); end
      checks++; if (allocated_runway !== 2'd2) begin errors++; $display("FAIL bw_runway: got %0d expected 2", allocated_runway); end
      takeoff_signal = 1'b0;
      drain();
   endtask

   task automatic test_weather_hold;
      weather = 1'b0; land_req = 1'b1; fuel = 2'b01;
      tick();
      checks++; if (timer_active !== 1'b1) begin errors++; $display("FAIL wx_active: got %b expected 1", timer_active); end
      checks++; if (timer_value !== 4'd12) begin errors++; $display("FAIL wx_load: got %0d expected 12", timer_value); end
      checks++; if (land_grant !== 1'b0) begin errors++; $display("FAIL wx_no_grant: got %b expected 0", land_grant); end
      for (int k = 11; k >= 0; k--) begin
         tick();
         checks++; if (timer_value !== 4'(k)) begin errors++; $display("FAIL wx_count%0d: got %0d expected %0d", k, timer_value, k); end
         checks++; if (land_grant !== 1'b0 || timer_active !== 1'b1) begin errors++; $display("FAIL wx_held%0d: got grant %b active %b expected 0 1", k, land_grant, timer_active); end
      end
      weather = 1'b1;
      tick();
      checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL wx_exit: got %b expected 0", timer_active); end
      tick();
      checks++; if (land_grant !== 1'b1 || allocated_runway !== 2'd0) begin errors++; $display("FAIL wx_land_after: got %b/%0d expected 1/0", land_grant, allocated_runway); end
      land_req = 1'b0;
      drain();
   endtask

   task automatic test_hold_priority;
      weather = 1'b0;
      tick();
      checks++; if (timer_value !== 4'd12) begin errors++; $display("FAIL hp_load: got %0d expected 12", timer_value); end
      tick();
      tick();
      land_req = 1'b1; fuel = 2'b00;
      tick();
      checks++; if (land_grant !== 1'b1 || allocated_runway !== 2'd0) begin errors++; $display("FAIL hp_grant: got %b/%0d expected 1/0", land_grant, allocated_runway); end
      checks++; if (timer_value !== 4'd9 || timer_active !== 1'b1) begin errors++; $display("FAIL hp_timer: got %0d/%b expected 9/1", timer_value, timer_active); end
      land_req = 1'b0; fuel = 2'b01;
      tick();
      checks++; if (timer_value !== 4'd8 || land_grant !== 1'b0) begin errors++; $display("FAIL hp_resume: got %0d/%b expected 8/0", timer_value, land_grant); end
      land_req = 1'b1;
      tick();
      tick();
      checks++; if (land_grant !== 1'b0 || timer_value !== 4'd6) begin errors++; $display("FAIL hp_normal_held: got %b/%0d expected 0/6", land_grant, timer_value); end
      land_req = 1'b0;
   endtask

   task automatic test_reset_mid_hold;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL rmh_active: got %b expected 0", timer_active); end
      checks++; if (timer_value !== 4'd0) begin errors++; $display("FAIL rmh_value: got %0d expected 0", timer_value); end
      checks++; if (runway_busy !== 4'b0000) begin errors++; $display("FAIL rmh_busy: got %b expected 0000", runway_busy); end
      land_req = 1'b1; emergency = 1'b1; weather = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      checks++; if (land_grant !== 1'b1 || allocated_runway !== 2'd0) begin errors++; $display("FAIL rmh_release_grant: got %b/%0d expected 1/0", land_grant, allocated_runway); end
      land_req = 1'b0; emergency = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_emergency();
      test_simultaneous();
      test_excess_fuel();
      test_alternate();
      test_busy_wait();
      test_weather_hold();
      test_hold_priority();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete within time limit");
      $fatal(1);
   end

endmodule
